// File: rtl/skinny_sbox8_dom1_seq_ctrl.sv
// Sequencer for one DOM1 non-complete SKINNY sbox8 datapath.
// Ports: in_*/si* share input, rnd_* RNG mask fetch, sb_* held operands and
// one-hot phase vector (cycle) to the sbox, sb_bo* sbox result, out_*/bo*
// result handshake, busy. Optional macro: SKINNY_SEQ_CLEAR_EN zeroes the
// hold regs when returning to IDLE.
module skinny_sbox8_dom1_seq_ctrl #(
  parameter int NSTAGE = 4,
  parameter int NSUB   = 6,
  parameter int CW     = NSTAGE * NSUB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    si1,
  input  logic [7:0]    si0,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  input  logic [7:0]    rnd,
  output logic [7:0]    sb_si1,
  output logic [7:0]    sb_si0,
  output logic [7:0]    sb_r,
  output logic [CW-1:0] cycle,
  input  logic [7:0]    sb_bo1,
  input  logic [7:0]    sb_bo0,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    bo1,
  output logic [7:0]    bo0,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, WAIT_RND, RUN, DONE
  } state_t;

  localparam int KW = $clog2(CW);
  localparam logic [KW-1:0] KLAST = KW'(CW - 1);

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] cyc_q;
  logic [7:0]    si1_q;
  logic [7:0]    si0_q;
  logic [7:0]    r_q;
  logic          idle_q;
  logic          rnd_rdy_q;
  logic          out_vld_q;
  logic          busy_q;

  // DONE accepts a new byte in the same cycle the result leaves.
  assign in_ready  = idle_q | (out_vld_q & out_ready);
  assign rnd_ready = rnd_rdy_q;
  assign out_valid = out_vld_q;
  assign busy      = busy_q;
  assign cycle     = cyc_q;
  assign sb_si1    = si1_q;
  assign sb_si0    = si0_q;
  assign sb_r      = r_q;
  assign bo1       = out_vld_q ? sb_bo1 : 8'h00;
  assign bo0       = out_vld_q ? sb_bo0 : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cyc_q     <= '0;
      si1_q     <= 8'h00;
      si0_q     <= 8'h00;
      r_q       <= 8'h00;
      idle_q    <= 1'b1;
      rnd_rdy_q <= 1'b0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            si1_q     <= si1;
            si0_q     <= si0;
            state_q   <= WAIT_RND;
            idle_q    <= 1'b0;
            rnd_rdy_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        WAIT_RND: begin
          if (rnd_valid) begin
            r_q       <= rnd;
            k_q       <= '0;
            cyc_q     <= CW'(1);
            state_q   <= RUN;
            rnd_rdy_q <= 1'b0;
          end
        end
        RUN: begin
          if (k_q == KLAST) begin
            cyc_q     <= '0;
            state_q   <= DONE;
            out_vld_q <= 1'b1;
          end else begin
            k_q   <= k_q + KW'(1);
            cyc_q <= cyc_q << 1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_vld_q <= 1'b0;
            if (in_valid) begin
              si1_q     <= si1;
              si0_q     <= si0;
              state_q   <= WAIT_RND;
              rnd_rdy_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              idle_q  <= 1'b1;
              busy_q  <= 1'b0;
`ifdef SKINNY_SEQ_CLEAR_EN
              si1_q   <= 8'h00;
              si0_q   <= 8'h00;
              r_q     <= 8'h00;
`else
              si1_q   <= si1_q;
`endif
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_dom1_seq_ctrl.sv
// Testbench for skinny_sbox8_dom1_seq_ctrl with a behavioural sbox stub
// that only yields S8 after seeing all 24 phases in order.
module tb_skinny_sbox8_dom1_seq_ctrl;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    si1 = '0;
  logic [7:0]    si0 = '0;
  logic          rnd_valid = 1'b0;
  logic          rnd_ready;
  logic [7:0]    rnd = '0;
  logic [7:0]    sb_si1;
  logic [7:0]    sb_si0;
  logic [7:0]    sb_r;
  logic [CW-1:0] cycle;
  logic [7:0]    sb_bo1;
  logic [7:0]    sb_bo0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    bo1;
  logic [7:0]    bo0;
  logic          busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int stub_err = 0;
  int ph = 0;

  always #5 clk = ~clk;

  skinny_sbox8_dom1_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .si1(si1), .si0(si0),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .sb_si1(sb_si1), .sb_si0(sb_si0), .sb_r(sb_r),
    .cycle(cycle),
    .sb_bo1(sb_bo1), .sb_bo0(sb_bo0),
    .out_valid(out_valid), .out_ready(out_ready),
    .bo1(bo1), .bo0(bo0), .busy(busy)
  );

  function automatic logic [7:0] perm(input logic [7:0] a);
    return ((a & 8'h01) << 2) | ((a & 8'h06) << 5) |
           ((a & 8'h20) >> 5) | ((a & 8'hC8) >> 2) |
           ((a & 8'h10) >> 1);
  endfunction

  // SKINNY-128 S8 built from its NOR/XOR round and bit permutation.
  function automatic logic [7:0] s8(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int i = 0; i < 4; i++) begin
      x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
      if (i < 3) x = perm(x);
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  // Sbox stub: garbage while computing, masked S8 after phase 23.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph     <= 0;
      sb_bo0 <= 8'h00;
      sb_bo1 <= 8'h00;
    end else if (cycle != '0) begin
      if (cycle != (24'd1 << ph)) stub_err <= stub_err + 1;
      if (ph == 0) sb_bo0 <= 8'($urandom);
      if (ph == CW - 1) begin
        sb_bo0 <= s8(sb_si0 ^ sb_si1) ^ sb_r;
        sb_bo1 <= sb_r;
        ph     <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  // Drives one operation; measures latency, phases, hold regs, rnd handshakes.
  task automatic run_op(
    input logic [7:0] s1, input logic [7:0] s0, input logic [7:0] r,
    input int rdly, input bit ordy, input bit pre,
    output int lat, output logic [7:0] res, output int bad,
    output int nrnd, output bit tmo);
    int n;
    int L;
    lat = 0; res = '0; bad = 0; nrnd = 0; tmo = 0; L = -1;
    out_ready = ordy; rnd = r; rnd_valid = 1'b0;
    if (!pre) begin
      in_valid = 1'b1; si1 = s1; si0 = s0;
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        tmo = 1; in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (lat = 1; lat < 300; lat++) begin
      if (out_valid) break;
      if (L > 0 && lat > L && lat <= L + 24) begin
        if (cycle !== (24'd1 << (lat - L - 1))) bad++;
        if (sb_si1 !== s1 || sb_si0 !== s0 || sb_r !== r) bad++;
      end else if (cycle !== '0) bad++;
      if (lat >= 1 + rdly) rnd_valid = 1'b1;
      if (rnd_valid && rnd_ready) begin
        nrnd++;
        if (L < 0) L = lat;
      end
      @(negedge clk);
    end
    rnd_valid = 1'b0;
    if (!out_valid) begin
      tmo = 1;
      return;
    end
    if (cycle !== '0) bad++;
    res = bo0 ^ bo1;
    if (ordy) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (cycle !== '0 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_ctl cycle=%h ov=%b busy=%b exp 0",
               cycle, out_valid, busy);
    else pass_cnt++;
    chk_cnt++;
    if (rnd_ready !== 1'b0 || bo0 !== 8'h00 || bo1 !== 8'h00)
      $display("FAIL reset_out rr=%b bo=%h/%h exp 0", rnd_ready, bo1, bo0);
    else pass_cnt++;
    chk_cnt++;
    if (sb_si1 !== 8'h00 || sb_si0 !== 8'h00 || sb_r !== 8'h00)
      $display("FAIL reset_hold %h %h %h exp 0", sb_si1, sb_si0, sb_r);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat, bad, nr;
    logic [7:0] res;
    bit tmo;
    run_op(8'hA5, 8'hA5, 8'h3E, 0, 1'b1, 1'b0, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || lat != 26)
      $display("FAIL basic_latency got %0d tmo=%b exp 26", lat, tmo);
    else pass_cnt++;
    chk_cnt++;
    if (res !== 8'h65) $display("FAIL basic_result got %h exp 65", res);
    else pass_cnt++;
    chk_cnt++;
    if (bad != 0 || nr != 1)
      $display("FAIL basic_seq bad=%0d nrnd=%0d exp 0/1", bad, nr);
    else pass_cnt++;
  endtask

  task automatic test_rnd_delay;
    int lat, bad, nr;
    logic [7:0] res;
    bit tmo;
    run_op(8'hC3, 8'h3C, 8'h5A, 7, 1'b1, 1'b0, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || lat != 33)
      $display("FAIL delay_latency got %0d tmo=%b exp 33", lat, tmo);
    else pass_cnt++;
    chk_cnt++;
    if (res !== 8'hFF) $display("FAIL delay_result got %h exp ff", res);
    else pass_cnt++;
    chk_cnt++;
    if (bad != 0 || nr != 1)
      $display("FAIL delay_seq bad=%0d nrnd=%0d exp 0/1", bad, nr);
    else pass_cnt++;
  endtask

  task automatic test_sweep;
    int lat, bad, nr, d;
    logic [7:0] res, s0, r;
    bit tmo;
    for (int x = 0; x < 256; x++) begin
      s0 = 8'($urandom);
      r  = 8'($urandom);
      d  = $urandom_range(0, 3);
      run_op(s0 ^ 8'(x), s0, r, d, 1'b1, 1'b0, lat, res, bad, nr, tmo);
      chk_cnt++;
      if (res !== s8(8'(x)))
        $display("FAIL sweep_result x=%h got %h exp %h", x, res, s8(8'(x)));
      else pass_cnt++;
      chk_cnt++;
      if (tmo || lat != 26 + d)
        $display("FAIL sweep_latency x=%h got %0d exp %0d", x, lat, 26 + d);
      else pass_cnt++;
      chk_cnt++;
      if (bad != 0 || nr != 1)
        $display("FAIL sweep_seq x=%h bad=%0d nrnd=%0d exp 0/1", x, bad, nr);
      else pass_cnt++;
    end
    chk_cnt++;
    if (stub_err != 0)
      $display("FAIL sweep_phase_order got %0d exp 0", stub_err);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    int lat, bad, nr, errs;
    logic [7:0] res, b0, b1;
    bit tmo;
    run_op(8'h12, 8'h34, 8'h77, 1, 1'b0, 1'b0, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || res !== s8(8'h26))
      $display("FAIL hold_result got %h exp %h", res, s8(8'h26));
    else pass_cnt++;
    b0 = bo0; b1 = bo1; errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bo0 !== b0 || bo1 !== b1 || cycle !== '0 || out_valid !== 1'b1)
        errs++;
    end
    chk_cnt++;
    if (errs != 0) $display("FAIL hold_stable got %0d bad cycles exp 0", errs);
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || bo0 !== 8'h00 || bo1 !== 8'h00 || busy !== 1'b0)
      $display("FAIL hold_release ov=%b bo=%h/%h busy=%b exp 0",
               out_valid, bo1, bo0, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bad, nr;
    logic [7:0] res;
    bit tmo;
    run_op(8'h0F, 8'hF0, 8'h11, 0, 1'b0, 1'b0, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || res !== s8(8'hFF) || nr != 1)
      $display("FAIL b2b_first got %h nrnd=%0d exp %h/1", res, nr, s8(8'hFF));
    else pass_cnt++;
    in_valid = 1'b1; si1 = 8'h9C; si0 = 8'h42; out_ready = 1'b1;
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1)
      $display("FAIL b2b_passthru in_ready got %b exp 1", in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || rnd_ready !== 1'b1)
      $display("FAIL b2b_no_idle ov=%b busy=%b rr=%b exp 0/1/1",
               out_valid, busy, rnd_ready);
    else pass_cnt++;
    run_op(8'h9C, 8'h42, 8'hA0, 0, 1'b1, 1'b1, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || lat != 26 || res !== s8(8'hDE) || bad != 0 || nr != 1)
      $display("FAIL b2b_second got %h lat=%0d bad=%0d nrnd=%0d exp %h/26/0/1",
               res, lat, bad, nr, s8(8'hDE));
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    int lat, bad, nr, n, errs;
    logic [7:0] res;
    bit tmo;
    in_valid = 1'b1; si1 = 8'h55; si0 = 8'h11; out_ready = 1'b1;
    rnd = 8'h0A; rnd_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0; rnd_valid = 1'b1;
    repeat (10) @(negedge clk);
    rnd_valid = 1'b0;
    chk_cnt++;
    if (cycle !== (24'd1 << 9))
      $display("FAIL rst_pre_k9 cycle got %h exp %h", cycle, 24'd1 << 9);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (cycle !== '0 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid cycle=%h ov=%b busy=%b exp 0",
               cycle, out_valid, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || cycle !== '0) errs++;
    end
    chk_cnt++;
    if (errs != 0) $display("FAIL rst_no_partial got %0d exp 0", errs);
    else pass_cnt++;
    run_op(8'h80, 8'h01, 8'hC4, 2, 1'b1, 1'b0, lat, res, bad, nr, tmo);
    chk_cnt++;
    if (tmo || lat != 28 || res !== s8(8'h81) || bad != 0 || nr != 1)
      $display("FAIL rst_next_op got %h lat=%0d bad=%0d exp %h/28/0",
               res, lat, bad, s8(8'h81));
    else pass_cnt++;
  endtask

  task automatic test_clear;
    int lat, bad, nr;
    logic [7:0] res, e1, e0, er;
    bit tmo;
    run_op(8'hE7, 8'h19, 8'h6B, 0, 1'b1, 1'b0, lat, res, bad, nr, tmo);
`ifdef SKINNY_SEQ_CLEAR_EN
    e1 = 8'h00; e0 = 8'h00; er = 8'h00;
`else
    e1 = 8'hE7; e0 = 8'h19; er = 8'h6B;
`endif
    chk_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clear_idle busy=%b in_ready=%b exp 0/1", busy, in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (sb_si1 !== e1 || sb_si0 !== e0 || sb_r !== er)
      $display("FAIL clear_hold got %h %h %h exp %h %h %h",
               sb_si1, sb_si0, sb_r, e1, e0, er);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rnd_delay();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_clear();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
